// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, pixel latency and payload types for the scan-out and pixel-source blocks.
package vga_pkg;

    localparam int unsigned CNT_W   = 11;
    localparam int unsigned RGB_W   = 24;
    localparam int unsigned CNT_MAX = 2047;

    localparam int unsigned H_VISIBLE_DEF = 800;
    localparam int unsigned H_FRONT_DEF   = 40;
    localparam int unsigned H_SYNC_DEF    = 48;
    localparam int unsigned H_BACK_DEF    = 40;
    localparam int unsigned V_VISIBLE_DEF = 480;
    localparam int unsigned V_FRONT_DEF   = 13;
    localparam int unsigned V_SYNC_DEF    = 3;
    localparam int unsigned V_BACK_DEF    = 29;

    localparam logic        SYNC_POL_DEF      = 1'b0;
    localparam int unsigned PIXEL_LATENCY_DEF = 2;

    localparam logic [RGB_W-1:0] RGB_BLACK = 24'h000000;

    typedef enum logic {
        ACTIVE_LINE = 1'b0,
        BLANK_LINE  = 1'b1
    } line_state_e;

    // Per-pixel control bundle carried through the latency-alignment pipeline.
    typedef struct packed {
        logic de;
        logic hsync;
        logic vsync;
    } vga_ctl_t;

endpackage

// File: rtl/vga_counter.sv
// Horizontal/vertical scan counters with the active/blank line FSM and raw (undelayed) timing decode.
module vga_counter
    import vga_pkg::*;
#(
    parameter int unsigned H_VISIBLE = H_VISIBLE_DEF,
    parameter int unsigned H_FRONT   = H_FRONT_DEF,
    parameter int unsigned H_SYNC    = H_SYNC_DEF,
    parameter int unsigned H_BACK    = H_BACK_DEF,
    parameter int unsigned V_VISIBLE = V_VISIBLE_DEF,
    parameter int unsigned V_FRONT   = V_FRONT_DEF,
    parameter int unsigned V_SYNC    = V_SYNC_DEF,
    parameter int unsigned V_BACK    = V_BACK_DEF,
    parameter logic        SYNC_POL  = SYNC_POL_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    output logic [CNT_W-1:0] vga_h,
    output logic [CNT_W-1:0] vga_v,
    output logic             vblank,
    output logic             frame_start,
    output logic             raw_de_c,
    output logic             raw_hsync_c,
    output logic             raw_vsync_c
);

    localparam int unsigned H_TOTAL_I = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL_I = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    // Totals must fit the 11-bit counters.
    if (H_TOTAL_I > CNT_MAX || V_TOTAL_I > CNT_MAX) begin : g_bad_total
        $error("vga_counter: H/V timing totals exceed 11-bit range");
    end

    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL_I - 1);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL_I - 1);
    localparam logic [CNT_W-1:0] H_VIS      = CNT_W'(H_VISIBLE);
    localparam logic [CNT_W-1:0] V_VIS      = CNT_W'(V_VISIBLE);
    localparam logic [CNT_W-1:0] H_SYNC_BEG = CNT_W'(H_VISIBLE + H_FRONT);
    localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [CNT_W-1:0] V_SYNC_BEG = CNT_W'(V_VISIBLE + V_FRONT);
    localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [CNT_W-1:0] h_q, h_d;
    logic [CNT_W-1:0] v_q, v_d;
    line_state_e      state_q, state_d;
    logic             run_q;
    logic             fs_q, fs_d;
    logic             line_wrap;

    // State and counter registers; run_q holds the first post-reset clock at 0/0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h_q     <= '0;
            v_q     <= '0;
            state_q <= ACTIVE_LINE;
            run_q   <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            h_q     <= h_d;
            v_q     <= v_d;
            state_q <= state_d;
            run_q   <= 1'b1;
            fs_q    <= fs_d;
        end
    end

    // Next counter values and line-type transitions, only at the line wrap.
    always_comb begin
        h_d       = h_q;
        v_d       = v_q;
        state_d   = state_q;
        line_wrap = 1'b0;
        if (!run_q) begin
            h_d     = '0;
            v_d     = '0;
            state_d = ACTIVE_LINE;
        end else begin
            if (h_q == H_LAST) begin
                line_wrap = 1'b1;
                h_d       = '0;
                v_d       = (v_q == V_LAST) ? '0 : v_q + 11'd1;
            end else begin
                h_d = h_q + 11'd1;
            end
            case (state_q)
                ACTIVE_LINE: if (line_wrap && v_d >= V_VIS) state_d = BLANK_LINE;
                BLANK_LINE:  if (line_wrap && v_d <  V_VIS) state_d = ACTIVE_LINE;
                default:     state_d = ACTIVE_LINE;
            endcase
        end
        fs_d = (h_d == '0) && (v_d == '0);
    end

    assign vga_h       = h_q;
    assign vga_v       = v_q;
    assign frame_start = fs_q;
    assign vblank      = (state_q == BLANK_LINE);

    // Raw timing decode; forced idle until the counters start running.
    assign raw_de_c    = run_q && (h_q < H_VIS) && (v_q < V_VIS);
    assign raw_hsync_c = (run_q && h_q >= H_SYNC_BEG && h_q < H_SYNC_END) ? SYNC_POL : ~SYNC_POL;
    assign raw_vsync_c = (run_q && v_q >= V_SYNC_BEG && v_q < V_SYNC_END) ? SYNC_POL : ~SYNC_POL;

endmodule

// File: rtl/vga_scan.sv
// VGA scan-out: drives pixel coordinates, aligns de/sync to the pixel source latency and registers RGB.
module vga_scan
    import vga_pkg::*;
#(
    parameter int unsigned H_VISIBLE     = H_VISIBLE_DEF,
    parameter int unsigned H_FRONT       = H_FRONT_DEF,
    parameter int unsigned H_SYNC        = H_SYNC_DEF,
    parameter int unsigned H_BACK        = H_BACK_DEF,
    parameter int unsigned V_VISIBLE     = V_VISIBLE_DEF,
    parameter int unsigned V_FRONT       = V_FRONT_DEF,
    parameter int unsigned V_SYNC        = V_SYNC_DEF,
    parameter int unsigned V_BACK        = V_BACK_DEF,
    parameter logic        SYNC_POL      = SYNC_POL_DEF,
    parameter int unsigned PIXEL_LATENCY = PIXEL_LATENCY_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [10:0] vga_h,
    output logic [10:0] vga_v,
    input  logic [23:0] pixel_in,
    output logic [23:0] rgb,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic        vblank,
    output logic        frame_start
);

    // Pixel source latency must be 1..7 clocks.
    if (PIXEL_LATENCY < 1 || PIXEL_LATENCY > 7) begin : g_bad_latency
        $error("vga_scan: PIXEL_LATENCY out of range 1..7");
    end

    localparam vga_ctl_t CTL_IDLE = '{de: 1'b0, hsync: ~SYNC_POL, vsync: ~SYNC_POL};

    vga_ctl_t                       raw_ctl;
    vga_ctl_t [PIXEL_LATENCY-1:0]   pipe_q;
    vga_ctl_t [PIXEL_LATENCY:0]     shift_c;
    vga_ctl_t                       tap_c;

    vga_counter #(
        .H_VISIBLE (H_VISIBLE),
        .H_FRONT   (H_FRONT),
        .H_SYNC    (H_SYNC),
        .H_BACK    (H_BACK),
        .V_VISIBLE (V_VISIBLE),
        .V_FRONT   (V_FRONT),
        .V_SYNC    (V_SYNC),
        .V_BACK    (V_BACK),
        .SYNC_POL  (SYNC_POL)
    ) u_counter (
        .clk         (clk),
        .reset_n     (reset_n),
        .vga_h       (vga_h),
        .vga_v       (vga_v),
        .vblank      (vblank),
        .frame_start (frame_start),
        .raw_de_c    (raw_ctl.de),
        .raw_hsync_c (raw_ctl.hsync),
        .raw_vsync_c (raw_ctl.vsync)
    );

    // Stage 0 is the raw decode; the tap lines up with pixel_in for the same coordinate.
    assign shift_c = {pipe_q, raw_ctl};
    assign tap_c   = pipe_q[PIXEL_LATENCY-1];

    // Delay pipeline plus the output register stage shared by rgb, de and syncs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pipe_q <= {PIXEL_LATENCY{CTL_IDLE}};
            de     <= 1'b0;
            hsync  <= ~SYNC_POL;
            vsync  <= ~SYNC_POL;
            rgb    <= RGB_BLACK;
        end else begin
            pipe_q <= shift_c[PIXEL_LATENCY-1:0];
            de     <= tap_c.de;
            hsync  <= tap_c.hsync;
            vsync  <= tap_c.vsync;
            rgb    <= tap_c.de ? pixel_in : RGB_BLACK;
        end
    end

endmodule

// File: tb/tb_vga_scan.sv
// Self-checking bench for vga_scan: a reduced-timing instance for whole-frame checks and a default instance.
module tb_vga_scan;

    localparam int LAT = 3;  // PIXEL_LATENCY + 1

    typedef struct {
        int hv, hf, hs, hb, vv, vf, vs, vb;
    } tim_t;

    typedef struct {
        int          cyc;
        logic [10:0] h, v;
        logic        de, hs, vs, vb, fs;
    } vec_t;

    typedef struct {
        int          cyc;
        logic [10:0] h, v;
        logic        hs;
    } fpt_t;

    logic clk = 1'b0;
    logic rst_s, rst_f;

    logic [10:0] s_h, s_v, f_h, f_v;
    logic [23:0] s_pix, s_rgb, f_pix, f_rgb;
    logic        s_hs, s_vs, s_de, s_vb, s_fs;
    logic        f_hs, f_vs, f_de, f_vb, f_fs;
    logic [50:0] vec_s, vec_f;

    always #5 clk = ~clk;

    vga_scan #(
        .H_VISIBLE(20), .H_FRONT(3), .H_SYNC(4), .H_BACK(5),
        .V_VISIBLE(12), .V_FRONT(2), .V_SYNC(3), .V_BACK(4),
        .SYNC_POL(1'b0), .PIXEL_LATENCY(2)
    ) dut_s (
        .clk(clk), .reset_n(rst_s), .vga_h(s_h), .vga_v(s_v), .pixel_in(s_pix),
        .rgb(s_rgb), .hsync(s_hs), .vsync(s_vs), .de(s_de), .vblank(s_vb), .frame_start(s_fs)
    );

    vga_scan dut_f (
        .clk(clk), .reset_n(rst_f), .vga_h(f_h), .vga_v(f_v), .pixel_in(f_pix),
        .rgb(f_rgb), .hsync(f_hs), .vsync(f_vs), .de(f_de), .vblank(f_vb), .frame_start(f_fs)
    );

    assign vec_s = {s_h, s_v, s_rgb, s_de, s_hs, s_vs, s_vb, s_fs};
    assign vec_f = {f_h, f_v, f_rgb, f_de, f_hs, f_vs, f_vb, f_fs};

    int   total = 0;
    int   passed = 0;
    int   n, nf;
    int   mode;
    logic s_live;
    logic stats_on;
    logic [23:0] pd_s, pd_f;
    int   rgb_nz, hs_low, hs_fall, vs_low, fs_cnt, vb_cnt;
    logic prev_hs;

    tim_t ts, tf;
    vec_t tbl[21];
    fpt_t fpts[6];

    localparam logic [50:0] RESET_VEC = {11'd0, 11'd0, 24'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    // Expected outputs at cycle k after release: coordinates from k, timing from k-LAT.
    function automatic logic [50:0] exp_vec(input tim_t t, input int k, input logic [23:0] pd);
        int ht, vt, h, v, m, mh, mv;
        logic act, hw, vw;
        ht = t.hv + t.hf + t.hs + t.hb;
        vt = t.vv + t.vf + t.vs + t.vb;
        h = k % ht;
        v = (k / ht) % vt;
        m = k - LAT;
        act = 1'b0; hw = 1'b0; vw = 1'b0; mh = 0; mv = 0;
        if (m >= 0) begin
            mh  = m % ht;
            mv  = (m / ht) % vt;
            act = (mh < t.hv) && (mv < t.vv);
            hw  = (mh >= t.hv + t.hf) && (mh < t.hv + t.hf + t.hs);
            vw  = (mv >= t.vv + t.vf) && (mv < t.vv + t.vf + t.vs);
        end
        return {11'(h), 11'(v), act ? pd : 24'h0, act, ~hw, ~vw, (v >= t.vv), (h == 0 && v == 0)};
    endfunction

    // Pixel-source model: pixel for the coordinate shown at cycle k.
    function automatic logic [23:0] pat(input tim_t t, input int k);
        int ht, vt, h, v;
        ht = t.hv + t.hf + t.hs + t.hb;
        vt = t.vv + t.vf + t.vs + t.vb;
        if (k < 0) return 24'h0;
        h = k % ht;
        v = (k / ht) % vt;
        return {8'(h), 8'(v), 8'h5A};
    endfunction

    task automatic chk(input string nm, input int idx, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got === want) passed++;
        else $display("FAIL %s @%0d got=%h want=%h", nm, idx, got, want);
    endtask

    // One clock: check both instances against the model, then drive the next pixel.
    task automatic tick();
        @(posedge clk);
        #1;
        nf++;
        chk("full_cyc", nf, 64'(vec_f), 64'(exp_vec(tf, nf, pd_f)));
        for (int i = 0; i < 6; i++)
            if (fpts[i].cyc == nf)
                chk("full_pt", nf, 64'({f_h, f_v, f_hs}), 64'({fpts[i].h, fpts[i].v, fpts[i].hs}));
        f_pix = pat(tf, nf - 2);
        pd_f  = f_pix;
        if (s_live) begin
            n++;
            chk("scan_cyc", n, 64'(vec_s), 64'(exp_vec(ts, n, pd_s)));
            if (stats_on) begin
                if (n >= LAT && n < LAT + 672) begin
                    rgb_nz  += (s_rgb != 24'h0) ? 1 : 0;
                    hs_low  += s_hs ? 0 : 1;
                    vs_low  += s_vs ? 0 : 1;
                    hs_fall += (prev_hs && !s_hs) ? 1 : 0;
                end
                if (n < 672) vb_cnt += s_vb ? 1 : 0;
                if (n < 2 * 672) fs_cnt += s_fs ? 1 : 0;
                prev_hs = s_hs;
            end
            case (mode)
                0:       s_pix = 24'hFFFFFF;
                1:       s_pix = pat(ts, n - 2);
                default: s_pix = 24'($urandom);
            endcase
            pd_s = s_pix;
        end
    endtask

    initial begin
        int guard;
        ts = '{20, 3, 4, 5, 12, 2, 3, 4};
        tf = '{800, 40, 48, 40, 480, 13, 3, 29};

        tbl[0]  = '{0,   11'd0,  11'd0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[1]  = '{2,   11'd2,  11'd0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{3,   11'd3,  11'd0,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{22,  11'd22, 11'd0,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{23,  11'd23, 11'd0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{26,  11'd26, 11'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{29,  11'd29, 11'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{30,  11'd30, 11'd0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{31,  11'd31, 11'd0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{32,  11'd0,  11'd1,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{35,  11'd3,  11'd1,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[11] = '{383, 11'd31, 11'd11, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[12] = '{384, 11'd0,  11'd12, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[13] = '{387, 11'd3,  11'd12, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[14] = '{448, 11'd0,  11'd14, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[15] = '{451, 11'd3,  11'd14, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[16] = '{546, 11'd2,  11'd17, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[17] = '{547, 11'd3,  11'd17, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[18] = '{671, 11'd31, 11'd20, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[19] = '{672, 11'd0,  11'd0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[20] = '{675, 11'd3,  11'd0,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

        fpts[0] = '{842,   11'd842, 11'd0,  1'b1};
        fpts[1] = '{843,   11'd843, 11'd0,  1'b0};
        fpts[2] = '{890,   11'd890, 11'd0,  1'b0};
        fpts[3] = '{891,   11'd891, 11'd0,  1'b1};
        fpts[4] = '{10207, 11'd927, 11'd10, 1'b1};
        fpts[5] = '{10208, 11'd0,   11'd11, 1'b1};

        rgb_nz = 0; hs_low = 0; hs_fall = 0; vs_low = 0; fs_cnt = 0; vb_cnt = 0;
        prev_hs = 1'b1;
        s_live = 1'b0; stats_on = 1'b0; mode = 0;
        s_pix = 24'h0; f_pix = 24'h0; pd_s = 24'h0; pd_f = 24'h0;
        rst_s = 1'b0; rst_f = 1'b0;

        // Reset state held across clock edges.
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state_s", 0, 64'(vec_s), 64'(RESET_VEC));
        chk("reset_state_f", 0, 64'(vec_f), 64'(RESET_VEC));

        @(negedge clk);
        rst_s = 1'b1; rst_f = 1'b1;
        n = -1; nf = -1;
        s_live = 1'b1; stats_on = 1'b1; mode = 0;
        s_pix = 24'hFFFFFF; pd_s = s_pix;

        // Hand-derived boundary points with constant white pixels.
        for (int i = 0; i < 21; i++) begin
            while (n < tbl[i].cyc) tick();
            chk("table", tbl[i].cyc, 64'({s_h, s_v, s_rgb, s_de, s_hs, s_vs, s_vb, s_fs}),
                64'({tbl[i].h, tbl[i].v, tbl[i].de ? 24'hFFFFFF : 24'h0,
                     tbl[i].de, tbl[i].hs, tbl[i].vs, tbl[i].vb, tbl[i].fs}));
        end
        while (n < 2 * 672 - 1) tick();
        stats_on = 1'b0;
        chk("frame_rgb_nonzero", n, 64'(rgb_nz), 64'(20 * 12));
        chk("frame_hsync_pulses", n, 64'(hs_fall), 64'(21));
        chk("frame_hsync_low", n, 64'(hs_low), 64'(21 * 4));
        chk("frame_vsync_low", n, 64'(vs_low), 64'(3 * 32));
        chk("frame_vblank_high", n, 64'(vb_cnt), 64'(9 * 32));
        chk("frame_start_count", n, 64'(fs_cnt), 64'(2));

        // Coordinate pattern, then random pixels.
        mode = 1;
        while (n < 3 * 672 - 1) tick();
        mode = 2;
        while (n < 4 * 672 - 1) tick();

        // Mid-frame reset inside the hsync pulse.
        guard = 0;
        while (!(n % 672 == 5 * 32 + 28) && guard < 2 * 672) begin
            tick();
            guard++;
        end
        chk("reset_point_found", n, 64'(n % 672), 64'(5 * 32 + 28));
        chk("pre_reset_hsync", n, 64'(s_hs), 64'(0));
        #2;
        rst_s = 1'b0;
        s_live = 1'b0;
        #1;
        chk("reset_async", n, 64'(vec_s), 64'(RESET_VEC));
        tick();
        tick();
        chk("reset_hold", n, 64'(vec_s), 64'(RESET_VEC));
        @(negedge clk);
        rst_s = 1'b1;
        n = -1;
        s_live = 1'b1;
        mode = 2;
        guard = 0;
        tick();
        while (s_hs && guard < 200) begin
            tick();
            guard++;
        end
        chk("hsync_restart", n, 64'(n), 64'(23 + LAT));

        // Let the default instance reach its line-10 wrap.
        while (nf < 10210) tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
